// File: rtl/digit_scanner.sv
// -----------------------------------------------------------------------------
// digit_scanner
//   Time-multiplexed driver for a four-digit BCD display. Each digit gets a
//   blanking gap of BLANK cycles followed by DWELL cycles in which it is
//   driven. One frame covers digits 0..3 and lasts 4*(DWELL+BLANK) cycles.
//   New display data is taken through a valid/ready handshake into a pending
//   register and committed only at the frame boundary, so a frame never shows
//   a mix of old and new digits. Nibbles above 9 blank their digit.
//
// Parameters
//   DWELL       cycles each digit is driven (>= 1)
//   BLANK       blanking cycles before each digit (>= 1)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load_valid  load_data is valid this cycle
//   load_ready  a load can be accepted this cycle
//   load_data   four BCD digits, [3:0] = digit0 (rightmost), [15:12] = digit3
//   number      BCD code of the digit currently driven (0 when not driving)
//   digit_en    one-hot digit select, bit i drives digit i
//   blank       high during blanking and during suppressed digits
//   frame_done  one-cycle pulse on the last driven cycle of digit3
// -----------------------------------------------------------------------------
module digit_scanner #(
  parameter int unsigned DWELL = 8,
  parameter int unsigned BLANK = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [3:0]  number,
  output logic [3:0]  digit_en,
  output logic        blank,
  output logic        frame_done
);

  localparam int unsigned MAXP = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0]   display_q, display_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_full_q, pend_full_d;

  logic          load_ready_q, load_ready_d;
  logic [3:0]    number_q, number_d;
  logic [3:0]    digit_en_q, digit_en_d;
  logic          blank_q, blank_d;
  logic          frame_done_q, frame_done_d;

  logic [3:0]    nibble;
  logic          accept;
  logic          commit;

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      GAP: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = GAP;
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = GAP;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load handshake and frame-boundary commit
  // ---------------------------------------------------------------------------
  // The registered ready already mirrors !pend_full_q, so the cycle that
  // clears pending still reports not-ready; acceptance resumes one cycle on.
  assign accept = load_valid && load_ready_q;
  // frame_done_q is high during the last driven cycle of the frame; the edge
  // that ends it is the frame boundary.
  assign commit = frame_done_q && pend_full_q;

  always_comb begin
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    display_d   = display_q;
    if (accept) begin
      pending_d   = load_data;
      pend_full_d = 1'b1;
    end else if (commit) begin
      display_d   = pending_q;
      pend_full_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode, registered one cycle behind the sequencer state
  // ---------------------------------------------------------------------------
  always_comb begin
    nibble = 4'd0;
    unique case (idx_q)
      2'd0: nibble = display_q[3:0];
      2'd1: nibble = display_q[7:4];
      2'd2: nibble = display_q[11:8];
      2'd3: nibble = display_q[15:12];
      default: nibble = 4'd0;
    endcase
  end

  always_comb begin
    number_d     = '0;
    digit_en_d   = '0;
    blank_d      = 1'b1;
    frame_done_d = 1'b0;
    load_ready_d = !pend_full_d;
    if (state_q == SHOW) begin
      // Non-BCD nibbles keep the blanked look for the whole dwell time.
      if (nibble <= 4'd9) begin
        number_d   = nibble;
        digit_en_d = 4'b0001 << idx_q;
        blank_d    = 1'b0;
      end
      frame_done_d = (idx_q == 2'd3) && (cnt_q == DWELL_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= GAP;
      idx_q        <= '0;
      cnt_q        <= '0;
      display_q    <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b0;
      number_q     <= '0;
      digit_en_q   <= '0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      load_ready_q <= load_ready_d;
      number_q     <= number_d;
      digit_en_q   <= digit_en_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign number     = number_q;
  assign digit_en   = digit_en_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scanner.sv
// -----------------------------------------------------------------------------
// tb_digit_scanner
//   Directed and randomized stimulus for digit_scanner. Expected outputs come
//   from a frame-position model: cycle t after reset release sits at position
//   (t-1) mod frame, which fixes digit, gap/show and frame_done directly;
//   display/pending follow the handshake and frame-boundary commit rules.
// -----------------------------------------------------------------------------
module tb_digit_scanner;

  localparam int D = 8;
  localparam int B = 2;
  localparam int P = D + B;
  localparam int F = 4 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  number;
  logic [3:0]  digit_en;
  logic        blank;
  logic        frame_done;

  digit_scanner #(.DWELL(D), .BLANK(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .number     (number),
    .digit_en   (digit_en),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          t = 0;          // cycle number since reset release
  logic [15:0] disp_m = '0;    // model display contents
  logic [15:0] pend_v = '0;    // model pending value
  logic        pend_m = 1'b0;  // model pending-full flag
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic int pos_of(input int cyc);
    return (cyc - 1) % F;
  endfunction

  function automatic logic fd_exp(input int cyc);
    return (pos_of(cyc) == F - 1);
  endfunction

  task automatic check_cycle();
    int          pos, dg, w, nib;
    logic [3:0]  en_e, num_e;
    logic        blk_e;
    pos   = pos_of(t);
    dg    = pos / P;
    w     = pos % P;
    nib   = (disp_m >> (dg * 4)) & 16'hF;
    en_e  = 4'b0000;
    num_e = 4'd0;
    blk_e = 1'b1;
    if (w >= B && nib <= 9) begin
      en_e  = 4'(1 << dg);
      num_e = 4'(nib);
      blk_e = 1'b0;
    end
    chk("digit_en",   16'(digit_en),   16'(en_e));
    chk("number",     16'(number),     16'(num_e));
    chk("blank",      16'(blank),      16'(blk_e));
    chk("frame_done", 16'(frame_done), 16'(fd_exp(t)));
    chk("load_ready", 16'(load_ready), 16'(!pend_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_digit_en"},   16'(digit_en),   16'h0);
    chk({tag, "_number"},     16'(number),     16'h0);
    chk({tag, "_blank"},      16'(blank),      16'h0);
    chk({tag, "_frame_done"}, 16'(frame_done), 16'h0);
    chk({tag, "_load_ready"}, 16'(load_ready), 16'h0);
  endtask

  // Check cycle t, drive the inputs for the edge ending it, advance the model.
  task automatic step(input logic v, input logic [15:0] d);
    check_cycle();
    load_valid = v;
    load_data  = d;
    last_acc   = 1'b0;
    if (v && !pend_m) begin
      pend_m   = 1'b1;
      pend_v   = d;
      last_acc = 1'b1;
    end else if (fd_exp(t) && pend_m) begin
      disp_m = pend_v;
      pend_m = 1'b0;
    end
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic release_reset();
    load_valid = 1'b0;
    load_data  = '0;
    rst_n      = 1'b1;
    t          = 0;
    disp_m     = '0;
    pend_v     = '0;
    pend_m     = 1'b0;
    @(posedge clk);
    t = 1;
    @(negedge clk);
  endtask

  task automatic load_until_accepted(input logic [15:0] d);
    for (int k = 0; k < 3 * F; k++) begin
      step(1'b1, d);
      if (last_acc) break;
    end
    load_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_digits();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(0, 11));
    return r;
  endfunction

  initial begin
    // Asynchronous reset: outputs clear with no clock edge involved.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    release_reset();

    // Idle frame, then load 0x1234 at cycle 15.
    while (t < 15) step(1'b0, '0);
    step(1'b1, 16'h1234);
    while (t < 20) step(1'b0, '0);
    // 0x5678 held from cycle 20 until accepted (cycle 41).
    load_until_accepted(16'h5678);
    while (t < 125) step(1'b0, '0);

    // Suppressed digit1.
    load_until_accepted(16'h00A0);
    while (t < 210) step(1'b0, '0);

    // Sparse random loads, including non-BCD nibbles.
    for (int k = 0; k < 400; k++) step(($urandom_range(0, 3) == 0), rnd_digits());
    // load_valid held high with changing data.
    for (int k = 0; k < 200; k++) step(1'b1, rnd_digits());
    load_valid = 1'b0;

    // Reset during digit2 SHOW with pending full.
    while (pend_m) step(1'b0, '0);
    load_until_accepted(16'h9876);
    for (int k = 0; k < F; k++) begin
      if ((pos_of(t) / P == 2) && (pos_of(t) % P >= B)) break;
      step(1'b0, '0);
    end
    check_cycle();
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid_held");
    release_reset();
    while (t < 2 * F + 2) step(1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0d observed=timeout expected=finish", t);
    $fatal(1, "watchdog expired");
  end

endmodule
